// File: rtl/button_pulse_conditioner_pkg.sv
// Shared definitions for the front-panel button conditioner: FSM encoding,
// default 100 MHz timing constants and a counter-width helper.
package button_pulse_conditioner_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        HELD   = 2'd1,
        REPEAT = 2'd2
    } btn_state_e;

    localparam int DEFAULT_DEBOUNCE_CNT  = 1000000;   // 10 ms
    localparam int DEFAULT_HOLD_CYCLES   = 50000000;  // 500 ms
    localparam int DEFAULT_REPEAT_CYCLES = 10000000;  // 100 ms

    // A count of 1 still needs a one-bit counter.
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/button_pulse_conditioner_sync.sv
// Multi-flop synchronizer for asynchronous panel inputs; the reset value is a
// parameter so the chain powers up at the input's inactive level.
module button_sync #(
    parameter int   STAGES    = 2,
    parameter logic RESET_VAL = 1'b1
) (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] sync_r;

    // Shift the raw input through the synchronizer chain.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_r <= {STAGES{RESET_VAL}};
        end else begin
            sync_r <= {sync_r[STAGES-2:0], d};
        end
    end

    assign q = sync_r[STAGES-1];

endmodule

// File: rtl/button_pulse_conditioner.sv
// Push-button conditioner: synchronize, debounce, and emit press/release
// strobes, with optional auto-repeat of the press strobe while held.
module button_pulse_conditioner
    import button_pulse_conditioner_pkg::*;
#(
    parameter int SYNC_STAGES   = 2,
    parameter int DEBOUNCE_CNT  = DEFAULT_DEBOUNCE_CNT,
    parameter int ACTIVE_LOW    = 1,
    parameter int HOLD_CYCLES   = DEFAULT_HOLD_CYCLES,
    parameter int REPEAT_CYCLES = DEFAULT_REPEAT_CYCLES
) (
    input  logic clk,
    input  logic reset,
    input  logic btn_raw,
    input  logic enable_repeat,
    output logic btn_level,
    output logic btn_press,
    output logic btn_release
);

    localparam logic INVERT = (ACTIVE_LOW != 0);
    localparam int   DB_W   = cnt_width(DEBOUNCE_CNT);
    localparam int   HOLD_W = cnt_width(HOLD_CYCLES);
    localparam int   REP_W  = cnt_width(REPEAT_CYCLES);

    localparam logic [DB_W-1:0]   DB_LAST   = DB_W'(DEBOUNCE_CNT - 1);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CYCLES - 1);
    localparam logic [REP_W-1:0]  REP_LAST  = REP_W'(REPEAT_CYCLES - 1);

    logic              sync_s;
    logic              pressed_s;
    logic              change_s;
    logic              rise_s;
    logic              fall_s;
    logic [DB_W-1:0]   db_cnt_r;
    logic              level_r;
    logic              press_r;
    logic              release_r;
    logic              press_s;
    logic              release_s;
    btn_state_e        state_r;
    btn_state_e        state_s;
    logic [HOLD_W-1:0] hold_cnt_r;
    logic [HOLD_W-1:0] hold_cnt_s;
    logic [REP_W-1:0]  rep_cnt_r;
    logic [REP_W-1:0]  rep_cnt_s;

    button_sync #(
        .STAGES    (SYNC_STAGES),
        .RESET_VAL (INVERT)
    ) u_sync (
        .clk   (clk),
        .reset (reset),
        .d     (btn_raw),
        .q     (sync_s)
    );

    assign pressed_s = sync_s ^ INVERT;
    assign change_s  = (pressed_s != level_r) && (db_cnt_r == DB_LAST);
    assign rise_s    = change_s && !level_r;
    assign fall_s    = change_s && level_r;

    // Debounce: the level follows the input only after DEBOUNCE_CNT stable cycles.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            db_cnt_r <= '0;
            level_r  <= 1'b0;
        end else if (pressed_s == level_r) begin
            db_cnt_r <= '0;
        end else if (db_cnt_r == DB_LAST) begin
            db_cnt_r <= '0;
            level_r  <= pressed_s;
        end else begin
            db_cnt_r <= db_cnt_r + DB_W'(1'b1);
        end
    end

    // Press/repeat FSM next-state and strobe decode; a release outranks a repeat.
    always_comb begin
        state_s    = state_r;
        hold_cnt_s = hold_cnt_r;
        rep_cnt_s  = rep_cnt_r;
        press_s    = 1'b0;
        release_s  = 1'b0;
        if (fall_s) begin
            state_s    = IDLE;
            hold_cnt_s = '0;
            rep_cnt_s  = '0;
            release_s  = 1'b1;
        end else begin
            case (state_r)
                IDLE: begin
                    if (rise_s) begin
                        state_s    = HELD;
                        hold_cnt_s = '0;
                        press_s    = 1'b1;
                    end else begin
                        hold_cnt_s = '0;
                    end
                end
                HELD: begin
                    if (!enable_repeat) begin
                        hold_cnt_s = '0;
                    end else if (hold_cnt_r == HOLD_LAST) begin
                        state_s   = REPEAT;
                        rep_cnt_s = '0;
                        press_s   = 1'b1;
                    end else begin
                        hold_cnt_s = hold_cnt_r + HOLD_W'(1'b1);
                    end
                end
                REPEAT: begin
                    if (!enable_repeat) begin
                        state_s    = HELD;
                        hold_cnt_s = '0;
                    end else if (rep_cnt_r == REP_LAST) begin
                        rep_cnt_s = '0;
                        press_s   = 1'b1;
                    end else begin
                        rep_cnt_s = rep_cnt_r + REP_W'(1'b1);
                    end
                end
                default: begin
                    state_s    = IDLE;
                    hold_cnt_s = '0;
                    rep_cnt_s  = '0;
                end
            endcase
        end
    end

    // FSM state, counters and registered strobes.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r    <= IDLE;
            hold_cnt_r <= '0;
            rep_cnt_r  <= '0;
            press_r    <= 1'b0;
            release_r  <= 1'b0;
        end else begin
            state_r    <= state_s;
            hold_cnt_r <= hold_cnt_s;
            rep_cnt_r  <= rep_cnt_s;
            press_r    <= press_s;
            release_r  <= release_s;
        end
    end

    assign btn_level   = level_r;
    assign btn_press   = press_r;
    assign btn_release = release_r;

endmodule

// File: tb/tb_button_pulse_conditioner.sv
// Scoreboard bench for button_pulse_conditioner: stimulus queues expected
// strobes with their cycle numbers; a monitor pops and compares each strobe.
module tb_button_pulse_conditioner;

    localparam int SYNC = 2;
    localparam int DB   = 8;
    localparam int HOLD = 20;
    localparam int REP  = 5;
    localparam int LAT  = SYNC + DB;

    logic clk = 1'b0;
    logic reset;
    logic btn_raw;
    logic enable_repeat;
    logic btn_level;
    logic btn_press;
    logic btn_release;

    typedef struct {
        bit is_press;
        int at;
    } ev_t;

    ev_t exp_q[$];
    int  cyc   = 0;
    int  tests = 0;
    int  fails = 0;
    bit  done  = 1'b0;

    button_pulse_conditioner #(
        .SYNC_STAGES   (SYNC),
        .DEBOUNCE_CNT  (DB),
        .ACTIVE_LOW    (1),
        .HOLD_CYCLES   (HOLD),
        .REPEAT_CYCLES (REP)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .btn_raw       (btn_raw),
        .enable_repeat (enable_repeat),
        .btn_level     (btn_level),
        .btn_press     (btn_press),
        .btn_release   (btn_release)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic push(input bit p, input int at);
        ev_t e;
        e.is_press = p;
        e.at       = at;
        exp_q.push_back(e);
    endtask

    task automatic wait_until(input int c);
        while (cyc < c) @(negedge clk);
    endtask

    // Monitor: reset-state checks, strobe scoreboard, final drain check.
    always @(negedge clk or posedge reset) begin
        ev_t e;
        #1;
        if (done) begin
            tests++;
            if (exp_q.size() != 0) begin
                fails++;
                $display("FAIL missing_strobes: %0d expected strobes not seen (first: press=%0d at cycle %0d)",
                         exp_q.size(), exp_q[0].is_press, exp_q[0].at);
            end
            $display("[TB] %0d tests run, %0d failed", tests, fails);
            $finish;
        end else if (reset) begin
            tests++;
            if ({btn_level, btn_press, btn_release} != 3'b000) begin
                fails++;
                $display("FAIL reset_outputs: level/press/release=%b%b%b required 000 at cycle %0d",
                         btn_level, btn_press, btn_release, cyc);
            end
        end else if (btn_press || btn_release) begin
            tests++;
            if (btn_press && btn_release) begin
                fails++;
                $display("FAIL press_and_release: both strobes high at cycle %0d", cyc);
            end else if (exp_q.size() == 0) begin
                fails++;
                $display("FAIL unexpected_strobe: press=%0d release=%0d at cycle %0d, none expected",
                         btn_press, btn_release, cyc);
            end else begin
                e = exp_q.pop_front();
                if (btn_press != e.is_press || cyc != e.at || btn_level != e.is_press) begin
                    fails++;
                    $display("FAIL strobe: got press=%0d level=%0d at cycle %0d, required press=%0d level=%0d at cycle %0d",
                             btn_press, btn_level, cyc, e.is_press, e.is_press, e.at);
                end
            end
        end
    end

    initial begin
        int t;
        reset         = 1'b1;
        btn_raw       = 1'b1;
        enable_repeat = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        repeat (5) @(negedge clk);

        // Clean press and release, repeat disabled.
        btn_raw = 1'b0;
        push(1'b1, cyc + LAT);
        repeat (40) @(negedge clk);
        btn_raw = 1'b1;
        push(1'b0, cyc + LAT);
        repeat (20) @(negedge clk);

        // Bounce every 3 cycles, then settle pressed.
        for (int i = 0; i < 10; i++) begin
            btn_raw = (i % 2 == 0) ? 1'b0 : 1'b1;
            repeat (3) @(negedge clk);
        end
        btn_raw = 1'b0;
        push(1'b1, cyc + LAT);
        repeat (30) @(negedge clk);
        btn_raw = 1'b1;
        push(1'b0, cyc + LAT);
        repeat (20) @(negedge clk);

        // 7-cycle glitch: must be filtered.
        btn_raw = 1'b0;
        repeat (7) @(negedge clk);
        btn_raw = 1'b1;
        repeat (20) @(negedge clk);

        // Auto-repeat; the release collides with a repeat slot at t+60.
        enable_repeat = 1'b1;
        t = cyc + LAT;
        btn_raw = 1'b0;
        push(1'b1, t);
        for (int k = HOLD; k <= 55; k += REP) push(1'b1, t + k);
        repeat (60) @(negedge clk);
        btn_raw = 1'b1;
        push(1'b0, t + 60);
        repeat (20) @(negedge clk);

        // Repeat disabled mid-hold, then re-enabled.
        t = cyc + LAT;
        btn_raw = 1'b0;
        push(1'b1, t);
        push(1'b1, t + 20);
        wait_until(t + 22);
        enable_repeat = 1'b0;
        wait_until(t + 30);
        enable_repeat = 1'b1;
        push(1'b1, t + 50);
        push(1'b1, t + 55);
        push(1'b1, t + 60);
        wait_until(t + 52);
        btn_raw = 1'b1;
        push(1'b0, t + 62);
        repeat (20) @(negedge clk);
        enable_repeat = 1'b0;

        // Reset while pressed; button still held afterwards.
        btn_raw = 1'b0;
        push(1'b1, cyc + LAT);
        repeat (15) @(negedge clk);
        #2 reset = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        push(1'b1, cyc + LAT);
        repeat (30) @(negedge clk);

        // Button released during reset: no strobes afterwards.
        #2 reset = 1'b1;
        @(negedge clk);
        btn_raw = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        repeat (30) @(negedge clk);

        done = 1'b1;
        repeat (10) @(negedge clk);
        $display("FAIL monitor_timeout: summary not reached");
        $fatal(1);
    end

endmodule
